// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports, sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   output logic                           ready,
   input  logic                           wen0,
   input  logic [ADDR_WIDTH-1:0]          waddr0,
   input  logic [DATA_WIDTH-1:0]          wdata0,
   input  logic                           wen1,
   input  logic [ADDR_WIDTH-1:0]          waddr1,
   input  logic [DATA_WIDTH-1:0]          wdata1,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rdata
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [ADDR_WIDTH-1:0]   w_ptr_next;
   logic [DATA_WIDTH-1:0]   r_rf [DEPTH];
   logic                    w_ready;
   logic                    w_accept;
   logic                    w_we0;
   logic                    w_we1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      case (r_state)
         S_CLEAR: begin
            w_ptr_next = r_ptr + 1'b1;
            if (r_ptr == ADDR_WIDTH'(DEPTH-1)) begin
               w_state_next = S_READY;
               w_ptr_next   = '0;
            end
         end
         S_READY: begin
            if (clr) begin
               w_state_next = S_CLEAR;
               w_ptr_next   = '0;
            end
         end
         default: begin
            w_state_next = S_CLEAR;
            w_ptr_next   = '0;
         end
      endcase
   end

   assign w_ready  = (r_state == S_READY);
   assign ready    = w_ready;
   // A clear request takes the edge, so any write presented with it is dropped.
   assign w_accept = w_ready & ~clr;
   assign w_we0    = w_accept & wen0 & ~((ZERO_REG != 0) && (waddr0 == '0));
   assign w_we1    = w_accept & wen1 & ~((ZERO_REG != 0) && (waddr1 == '0));

   // Storage has no reset; the clear engine owns zeroing. Port 1 is written last so it wins on collisions.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_rf[r_ptr] <= '0;
      end else begin
         if (w_we0) r_rf[waddr0] <= wdata0;
         if (w_we1) r_rf[waddr1] <= wdata1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] w_ra;
         logic [DATA_WIDTH-1:0] w_rd;

         assign w_ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

         always_comb begin
            w_rd = r_rf[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_we1 && (waddr1 == w_ra)) begin
               w_rd = wdata1;
            end else if (w_we0 && (waddr0 == w_ra)) begin
               w_rd = wdata0;
            end
`endif
            if (!w_ready || ((ZERO_REG != 0) && (w_ra == '0))) begin
               w_rd = '0;
            end
         end

         assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
      end
   endgenerate

endmodule
